// File: rtl/turbosound_pkg.sv
// -----------------------------------------------------------------------------
// turbosound_pkg
// Shared types and constants for the TurboSound AY bus sequencer.
//   seq_state_e  : sequencer step (idle, select, address, data, restores)
//   bus_drive_t  : one clock of AY bus drive (bdir, bc1, data)
//   AY_SEL_BASE  : upper seven bits of a TurboSound chip-select write
//   CHIP_AY1/2   : chip numbers; AY1 is selected by 0xFF, AY2 by 0xFE
// -----------------------------------------------------------------------------
package turbosound_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEL   = 3'd1,
        ST_ADDR  = 3'd2,
        ST_DATA  = 3'd3,
        ST_RADDR = 3'd4,
        ST_RSEL  = 3'd5
    } seq_state_e;

    localparam logic [6:0] AY_SEL_BASE = 7'h7F;
    localparam logic       CHIP_AY1    = 1'b0;
    localparam logic       CHIP_AY2    = 1'b1;

    typedef struct packed {
        logic       bdir;
        logic       bc1;
        logic [7:0] data;
    } bus_drive_t;

    localparam bus_drive_t BUS_IDLE = '{bdir: 1'b0, bc1: 1'b0, data: 8'h00};

    function automatic bus_drive_t bus_drive(input logic bdir, input logic bc1,
                                             input logic [7:0] data);
        bus_drive_t d;
        d.bdir = bdir;
        d.bc1  = bc1;
        d.data = data;
        return d;
    endfunction

    // Chip-select code: bit 0 is inverted chip number (0xFF = AY1, 0xFE = AY2).
    function automatic logic [7:0] sel_code(input logic chip);
        return {AY_SEL_BASE, ~chip};
    endfunction

endpackage

// File: rtl/ay_cpu_shadow.sv
// -----------------------------------------------------------------------------
// ay_cpu_shadow
// Tracks what the CPU believes the TurboSound chips hold: which chip is
// selected and each chip's latched register address. Every CPU address-latch
// cycle (bdir & bc1) either moves the selection (0xFE/0xFF, when the second
// chip exists) or latches an address into the currently selected chip.
// Ports:
//   clk, reset_n     : clock, synchronous active-low reset
//   wr_i             : CPU address-latch cycle this clock
//   sel_en_i         : selection writes are honoured (both chips enabled)
//   din_i            : CPU data bus
//   sel_o            : current selection (0 = AY1)
//   sel_nxt_o        : selection after this clock's update
//   addr_nxt_o       : per-chip latched address after this clock's update
// The *_nxt outputs let a consumer make decisions at the same edge the
// CPU changes the shadow.
// -----------------------------------------------------------------------------
module ay_cpu_shadow
    import turbosound_pkg::*;
(
    input  logic            clk,
    input  logic            reset_n,
    input  logic            wr_i,
    input  logic            sel_en_i,
    input  logic [7:0]      din_i,
    output logic            sel_o,
    output logic            sel_nxt_o,
    output logic [1:0][7:0] addr_nxt_o
);

    logic            sel_q, sel_d;
    logic [1:0][7:0] addr_q, addr_d;

    always_comb begin
        sel_d  = sel_q;
        addr_d = addr_q;
        if (wr_i) begin
            // With a chip disabled, 0xFE/0xFF is just an ordinary address.
            if (sel_en_i && (din_i[7:1] == AY_SEL_BASE)) begin
                sel_d = ~din_i[0];
            end else begin
                addr_d[sel_q] = din_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sel_q  <= CHIP_AY1;
            addr_q <= '0;
        end else begin
            sel_q  <= sel_d;
            addr_q <= addr_d;
        end
    end

    assign sel_o      = sel_q;
    assign sel_nxt_o  = sel_d;
    assign addr_nxt_o = addr_d;

endmodule

// File: rtl/turbosound_bus_sequencer.sv
// -----------------------------------------------------------------------------
// turbosound_bus_sequencer
// Shares the TurboSound AY bus between the Z80 port decoder and an internal
// register-write requester. The CPU always wins and is passed straight
// through. A queued write expands into chip select, address latch and data
// write, then the CPU's selected chip and latched address are put back.
// Parameters:
//   HOLD             : clocks each sequencer bus step is driven (>= 1);
//                      every step is followed by one idle gap clock
// Ports:
//   clk, reset_n     : clock, synchronous active-low reset
//   disable_ay       : AY subsystem off, requests are dropped
//   disable_turboay  : second AY off, chip-1 requests dropped, CPU select
//                      writes are treated as plain addresses
//   cpu_bdir/bc1/din : CPU side of the AY bus
//   req_*            : write request (valid/ready handshake, chip, reg, data)
//   bdir, bc1, dout  : AY bus towards turbosound
//   busy             : a sequence is in progress
// -----------------------------------------------------------------------------
module turbosound_bus_sequencer
    import turbosound_pkg::*;
#(
    parameter int unsigned HOLD = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       disable_ay,
    input  logic       disable_turboay,
    input  logic       cpu_bdir,
    input  logic       cpu_bc1,
    input  logic [7:0] cpu_din,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_chip,
    input  logic [3:0] req_reg,
    input  logic [7:0] req_data,
    output logic       bdir,
    output logic       bc1,
    output logic [7:0] dout,
    output logic       busy
);

    localparam int unsigned      CNT_W   = $clog2(HOLD + 1);
    localparam logic [CNT_W-1:0] CNT_GAP = CNT_W'(HOLD);

    logic            cpu_active;
    logic            accept;
    logic            drop;
    logic            sh_sel, sh_sel_nxt;
    logic [1:0][7:0] sh_addr_nxt;

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             chip_q, chip_d;
    logic [3:0]       reg_q, reg_d;
    logic [7:0]       data_q, data_d;
    bus_drive_t       drv_q, drv_d;

    assign cpu_active = cpu_bdir | cpu_bc1;
    assign req_ready  = (state_q == ST_IDLE) & ~cpu_active;
    assign accept     = req_valid & req_ready;
    assign drop       = disable_ay | ((req_chip == CHIP_AY2) & disable_turboay);
    assign busy       = (state_q != ST_IDLE);

    ay_cpu_shadow u_shadow (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_i       (cpu_bdir & cpu_bc1),
        .sel_en_i   (~disable_ay & ~disable_turboay),
        .din_i      (cpu_din),
        .sel_o      (sh_sel),
        .sel_nxt_o  (sh_sel_nxt),
        .addr_nxt_o (sh_addr_nxt)
    );

    // Next state / step counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        chip_d  = chip_q;
        reg_d   = reg_q;
        data_d  = data_q;
        if (state_q == ST_IDLE) begin
            if (accept) begin
                chip_d = req_chip;
                reg_d  = req_reg;
                data_d = req_data;
                cnt_d  = '0;
                if (!drop) begin
                    state_d = (req_chip != sh_sel) ? ST_SEL : ST_ADDR;
                end
            end
        end else if (cpu_active) begin
            // The CPU may be moving the selection or address latch right now,
            // so decide the resume point from the post-update shadow.
            cnt_d = '0;
            case (state_q)
                ST_RADDR, ST_RSEL: state_d = ST_RADDR;
                default:           state_d = (chip_q != sh_sel_nxt) ? ST_SEL : ST_ADDR;
            endcase
        end else if (cnt_q == CNT_GAP) begin
            cnt_d = '0;
            case (state_q)
                ST_SEL:   state_d = ST_ADDR;
                ST_ADDR:  state_d = ST_DATA;
                ST_DATA:  state_d = ST_RADDR;
                ST_RADDR: state_d = (chip_q != sh_sel) ? ST_RSEL : ST_IDLE;
                ST_RSEL:  state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Bus drive is decoded from the next state so the registered drive lines
    // up with state/cnt; restore values come from the live shadow.
    always_comb begin
        drv_d = BUS_IDLE;
        if (cnt_d != CNT_GAP) begin
            case (state_d)
                ST_SEL:   drv_d = bus_drive(1'b1, 1'b1, sel_code(chip_d));
                ST_ADDR:  drv_d = bus_drive(1'b1, 1'b1, {4'h0, reg_d});
                ST_DATA:  drv_d = bus_drive(1'b1, 1'b0, data_d);
                ST_RADDR: drv_d = bus_drive(1'b1, 1'b1, sh_addr_nxt[chip_d]);
                ST_RSEL:  drv_d = bus_drive(1'b1, 1'b1, sel_code(sh_sel_nxt));
                default:  drv_d = BUS_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            chip_q  <= CHIP_AY1;
            reg_q   <= '0;
            data_q  <= '0;
            drv_q   <= BUS_IDLE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            chip_q  <= chip_d;
            reg_q   <= reg_d;
            data_q  <= data_d;
            drv_q   <= drv_d;
        end
    end

    // CPU has zero-latency priority over the registered sequencer drive.
    assign bdir = cpu_active ? cpu_bdir : drv_q.bdir;
    assign bc1  = cpu_active ? cpu_bc1  : drv_q.bc1;
    assign dout = cpu_active ? cpu_din  : drv_q.data;

endmodule
